// File: rtl/captura_monto.sv
// Keypad amount entry for the ATM controller: accumulates decimal digits and strobes the confirmed amount.
// Optional build macro MONTO_LIMITE_EN rejects confirmed amounts above LIMITE.
//
// state    | meaning
// INACTIVO | controller not asking for an amount
// CAPTURA  | accumulating digits, waiting for enter/clear
// ENTREGA  | amount latched on MONTO, strobe issued next edge
// LIBERAR  | amount delivered, keys ignored until HABILITAR drops
module captura_monto #(
    parameter int unsigned      ANCHO       = 32,
    parameter int unsigned      MAX_DIGITOS = 9,
    parameter logic [ANCHO-1:0] LIMITE      = 32'd500000
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             HABILITAR,
    input  logic [3:0]       TECLA,
    input  logic             TECLA_STB,
    input  logic             TECLA_ENTER,
    input  logic             TECLA_BORRAR,
    output logic [ANCHO-1:0] MONTO,
    output logic             MONTO_STB,
    output logic [3:0]       DIGITOS,
    output logic             DESBORDE,
    output logic             RECHAZO
);

    typedef enum logic [1:0] {
        INACTIVO = 2'd0,
        CAPTURA  = 2'd1,
        ENTREGA  = 2'd2,
        LIBERAR  = 2'd3
    } estado_t;

    localparam logic [3:0] MAX_D = 4'(MAX_DIGITOS);

    estado_t          estado, estado_sig;
    logic [ANCHO-1:0] acum, acum_sig;
    logic [ANCHO-1:0] acum_x10;
    logic [ANCHO-1:0] monto_sig;
    logic [3:0]       digitos_sig;
    logic             stb_sig, desborde_sig, rechazo_sig;
    logic             es_digito, excede;

    assign es_digito = (TECLA <= 4'd9);
    assign acum_x10  = (acum << 3) + (acum << 1);

`ifdef MONTO_LIMITE_EN
    assign excede = (acum > LIMITE);
`else
    // LIMITE stays referenced so the parameter list is identical in both builds.
    assign excede = (acum > LIMITE) && 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            estado    <= INACTIVO;
            acum      <= '0;
            DIGITOS   <= '0;
            MONTO     <= '0;
            MONTO_STB <= 1'b0;
            DESBORDE  <= 1'b0;
            RECHAZO   <= 1'b0;
        end else begin
            estado    <= estado_sig;
            acum      <= acum_sig;
            DIGITOS   <= digitos_sig;
            MONTO     <= monto_sig;
            MONTO_STB <= stb_sig;
            DESBORDE  <= desborde_sig;
            RECHAZO   <= rechazo_sig;
        end
    end

    always_comb begin
        estado_sig   = estado;
        acum_sig     = acum;
        digitos_sig  = DIGITOS;
        monto_sig    = MONTO;
        stb_sig      = 1'b0;
        desborde_sig = 1'b0;
        rechazo_sig  = 1'b0;
        case (estado)
            INACTIVO: begin
                if (HABILITAR) begin
                    estado_sig  = CAPTURA;
                    acum_sig    = '0;
                    digitos_sig = '0;
                end
            end
            CAPTURA: begin
                // Losing HABILITAR mid-entry discards the entry silently.
                if (!HABILITAR) begin
                    estado_sig  = INACTIVO;
                    acum_sig    = '0;
                    digitos_sig = '0;
                end else if (TECLA_BORRAR) begin
                    acum_sig    = '0;
                    digitos_sig = '0;
                end else if (TECLA_ENTER) begin
                    if (DIGITOS == 4'd0 || excede) begin
                        rechazo_sig = 1'b1;
                    end else begin
                        monto_sig  = acum;
                        estado_sig = ENTREGA;
                    end
                end else if (TECLA_STB && es_digito) begin
                    if (DIGITOS < MAX_D) begin
                        acum_sig    = acum_x10 + {{(ANCHO-4){1'b0}}, TECLA};
                        digitos_sig = DIGITOS + 4'd1;
                    end else begin
                        desborde_sig = 1'b1;
                    end
                end
            end
            ENTREGA: begin
                stb_sig    = 1'b1;
                estado_sig = LIBERAR;
            end
            LIBERAR: begin
                if (!HABILITAR) estado_sig = INACTIVO;
            end
            default: estado_sig = INACTIVO;
        endcase
    end

endmodule

// File: tb/tb_captura_monto.sv
// Self-checking bench for captura_monto: directed scenarios then randomized keypad traffic against a digit-list model.
module tb_captura_monto;

    logic        CLK;
    logic        RESET;
    logic        HABILITAR;
    logic [3:0]  TECLA;
    logic        TECLA_STB;
    logic        TECLA_ENTER;
    logic        TECLA_BORRAR;
    logic [31:0] MONTO;
    logic        MONTO_STB;
    logic [3:0]  DIGITOS;
    logic        DESBORDE;
    logic        RECHAZO;

    captura_monto dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .HABILITAR    (HABILITAR),
        .TECLA        (TECLA),
        .TECLA_STB    (TECLA_STB),
        .TECLA_ENTER  (TECLA_ENTER),
        .TECLA_BORRAR (TECLA_BORRAR),
        .MONTO        (MONTO),
        .MONTO_STB    (MONTO_STB),
        .DIGITOS      (DIGITOS),
        .DESBORDE     (DESBORDE),
        .RECHAZO      (RECHAZO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    localparam longint LIM = 500000;
`ifdef MONTO_LIMITE_EN
    localparam bit LIM_ON = 1'b1;
`else
    localparam bit LIM_ON = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    // Reference: the entry is a list of typed digits; phase 0 idle, 1 entering, 2 confirmed, 3 delivered.
    int          fase = 0;
    int          q[$];
    logic [31:0] m_monto = '0;
    bit          e_stb, e_des, e_rech;

    function automatic longint valor();
        longint v = 0;
        foreach (q[i]) v = v * 10 + q[i];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        vectors++;
        assert (obs === exp_v) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick(input logic h, input logic r, input logic [3:0] t,
                        input logic s, input logic e, input logic b);
        @(negedge CLK);
        RESET = r; HABILITAR = h; TECLA = t;
        TECLA_STB = s; TECLA_ENTER = e; TECLA_BORRAR = b;
        @(posedge CLK);
        #1;
        e_stb = 0; e_des = 0; e_rech = 0;
        if (!r) begin
            fase = 0; q.delete(); m_monto = '0;
        end else begin
            case (fase)
                0: if (h) begin fase = 1; q.delete(); end
                1: begin
                    if (!h) begin
                        fase = 0; q.delete();
                    end else if (b) begin
                        q.delete();
                    end else if (e) begin
                        if (q.size() == 0 || (LIM_ON && valor() > LIM)) e_rech = 1;
                        else begin m_monto = 32'(valor()); fase = 2; end
                    end else if (s && t <= 9) begin
                        if (q.size() < 9) q.push_back(int'(t));
                        else e_des = 1;
                    end
                end
                2: begin e_stb = 1; fase = 3; end
                default: if (!h) fase = 0;
            endcase
        end
        chk("monto", MONTO, m_monto);
        chk("monto_stb", 32'(MONTO_STB), 32'(e_stb));
        chk("digitos", 32'(DIGITOS), 32'(q.size()));
        chk("desborde", 32'(DESBORDE), 32'(e_des));
        chk("rechazo", 32'(RECHAZO), 32'(e_rech));
        chk("flags_exclusive", 32'(DESBORDE & RECHAZO), 32'd0);
    endtask

    task automatic tecla(input int d);
        tick(1'b1, 1'b1, 4'(d), 1'b1, 1'b0, 1'b0);
    endtask
    task automatic enter();
        tick(1'b1, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0);
    endtask
    task automatic borrar();
        tick(1'b1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
    endtask
    task automatic espera(input logic h);
        tick(h, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    endtask
    task automatic nueva_ventana();
        espera(1'b0);
        espera(1'b1);
    endtask

    initial begin
        RESET = 1'b0; HABILITAR = 1'b0; TECLA = '0;
        TECLA_STB = 1'b0; TECLA_ENTER = 1'b0; TECLA_BORRAR = 1'b0;
        tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("reset_monto", MONTO, 32'd0);
        chk("reset_digitos", 32'(DIGITOS), 32'd0);

        // 1: 1250 with strobe one cycle after enter
        espera(1'b1);
        tecla(1); tecla(2); tecla(5); tecla(0);
        enter();
        chk("t1_monto", MONTO, 32'd1250);
        chk("t1_stb_not_yet", 32'(MONTO_STB), 32'd0);
        espera(1'b1);
        chk("t1_stb", 32'(MONTO_STB), 32'd1);
        espera(1'b1);
        chk("t1_stb_once", 32'(MONTO_STB), 32'd0);

        // 2: ten nines, tenth overflows
        nueva_ventana();
        for (int i = 0; i < 9; i++) tecla(9);
        tecla(9);
        chk("t2_desborde", 32'(DESBORDE), 32'd1);
        chk("t2_digitos", 32'(DIGITOS), 32'd9);
        enter();
        chk("t2_monto", MONTO, 32'd999999999);
        espera(1'b1);

        // 3: clear mid-entry, then empty enter
        nueva_ventana();
        tecla(4); borrar(); tecla(7); enter();
        chk("t3_monto", MONTO, 32'd7);
        espera(1'b1);
        nueva_ventana();
        enter();
        chk("t3_rechazo", 32'(RECHAZO), 32'd1);
        espera(1'b1);
        chk("t3_no_stb", 32'(MONTO_STB), 32'd0);

        // 4: HABILITAR drop discards; reset mid-entry
        tecla(3); tecla(4);
        nueva_ventana();
        tecla(5); enter();
        chk("t4_monto", MONTO, 32'd5);
        espera(1'b1);
        nueva_ventana();
        tecla(6); tecla(2);
        tick(1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("t4_reset_monto", MONTO, 32'd0);
        chk("t4_reset_digitos", 32'(DIGITOS), 32'd0);

        // 5: keys after delivery are ignored
        espera(1'b1);
        tecla(4); tecla(2); enter(); espera(1'b1);
        tecla(8); enter(); espera(1'b1);
        chk("t5_monto_held", MONTO, 32'd42);
        chk("t5_no_stb", 32'(MONTO_STB), 32'd0);

`ifdef MONTO_LIMITE_EN
        // 6: limit boundary
        nueva_ventana();
        tecla(5); tecla(0); tecla(0); tecla(0); tecla(0); tecla(1);
        enter();
        chk("t6_rechazo", 32'(RECHAZO), 32'd1);
        chk("t6_kept", 32'(DIGITOS), 32'd6);
        borrar();
        tecla(5); for (int i = 0; i < 5; i++) tecla(0);
        enter();
        chk("t6_monto", MONTO, 32'd500000);
        espera(1'b1);
        chk("t6_stb", 32'(MONTO_STB), 32'd1);
`endif

        for (int n = 0; n < 3000; n++) begin
            logic h, r, s, e, b;
            logic [3:0] t;
            h = ($urandom_range(0, 24) != 0);
            r = ($urandom_range(0, 299) != 0);
            s = ($urandom_range(0, 2) != 0);
            e = ($urandom_range(0, 9) == 0);
            b = ($urandom_range(0, 19) == 0);
            t = 4'($urandom_range(0, 11));
            tick(h, r, t, s, e, b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
